// File: rtl/bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
//   Multi-digit packed-BCD counter with a runtime-programmable wrap limit,
//   up/down counting, validated parallel load and a combinational carry/borrow
//   output for cascading into the enable of a following stage.
//   Digit 0 (least significant) sits in bits [3:0].
//
// Parameters
//   DIGITS : number of BCD digits (1..8); counter width is 4*DIGITS.
//
// Ports
//   clk    in   system clock, rising-edge active
//   rst_n  in   asynchronous active-low reset (q = 0, err = 0)
//   clr    in   synchronous clear, highest priority
//   ld     in   synchronous load of din (accepted only if valid BCD and <= lim)
//   din    in   BCD load value
//   en     in   count enable, one step per enabled clock
//   up     in   direction: 1 = up, 0 = down
//   lim    in   BCD wrap limit
//   q      out  registered count, always valid BCD
//   co     out  combinational carry/borrow, high when the enabled step wraps
//   err    out  registered one-cycle pulse on a rejected load
// -----------------------------------------------------------------------------
module bcd_counter #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                ld,
    input  logic [4*DIGITS-1:0] din,
    input  logic                en,
    input  logic                up,
    input  logic [4*DIGITS-1:0] lim,
    output logic [4*DIGITS-1:0] q,
    output logic                co,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT
    } cmp_t;

    // Decimal magnitude compare, most-significant digit first: the first
    // differing digit decides.
    function automatic cmp_t bcd_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        cmp_t res;
        res = CMP_EQ;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (res == CMP_EQ && a[4*i +: 4] != b[4*i +: 4]) begin
                res = (a[4*i +: 4] > b[4*i +: 4]) ? CMP_GT : CMP_LT;
            end
        end
        return res;
    endfunction

    function automatic logic bcd_valid(input logic [W-1:0] a);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Ripple-carry decimal increment. Only used when a < lim, so the top digit
    // never overflows.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic         c;
        r = a;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (a[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = a[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Ripple-borrow decimal decrement. Only used when a != 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic         b;
        r = a;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (a[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = a[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] r_q;
    logic         r_err;

    logic         w_q_zero;
    logic         w_q_ge_lim;
    logic         w_q_gt_lim;
    logic         w_ld_ok;
    logic [W-1:0] w_q_nxt;
    logic         w_err_nxt;
    cmp_t         w_q_vs_lim;

    assign w_q_vs_lim = bcd_cmp(r_q, lim);
    assign w_q_zero   = (r_q == '0);
    assign w_q_ge_lim = (w_q_vs_lim != CMP_LT);
    assign w_q_gt_lim = (w_q_vs_lim == CMP_GT);
    // An out-of-range din digit makes the load invalid whatever the compare says.
    assign w_ld_ok    = bcd_valid(din) && (bcd_cmp(din, lim) != CMP_GT);

    // The carry/borrow is masked by clr and ld because neither performs a step.
    assign co = en & ~clr & ~ld & ((up & w_q_ge_lim) | (~up & w_q_zero));

    always_comb begin
        // NOTE: every output of this block is given a default first so that no
        // path through the if/else chain leaves it unassigned (no latch).
        w_q_nxt   = r_q;
        w_err_nxt = 1'b0;
        if (clr) begin
            w_q_nxt = '0;
        end else if (ld) begin
            if (w_ld_ok) w_q_nxt   = din;
            else         w_err_nxt = 1'b1;
        end else if (en) begin
            if (up) begin
                w_q_nxt = w_q_ge_lim ? '0 : bcd_inc(r_q);
            end else if (w_q_zero || w_q_gt_lim) begin
                // Down from 0 wraps to lim; a count left above a lowered
                // limit snaps straight to lim.
                w_q_nxt = lim;
            end else begin
                w_q_nxt = bcd_dec(r_q);
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            r_err <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign q   = r_q;
    assign err = r_err;

endmodule

// File: tb/tb_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter
//   Directed self-checking bench for bcd_counter. A 2-digit instance covers the
//   seconds-counter behaviour; a 4-digit instance covers multi-digit carry.
// -----------------------------------------------------------------------------
module tb_bcd_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, ld, en, up;
    logic [7:0] din, lim, q;
    logic       co, err;

    logic        clr4, ld4, en4, up4;
    logic [15:0] din4, lim4, q4;
    logic        co4, err4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_counter #(.DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ld(ld), .din(din), .en(en),
        .up(up), .lim(lim), .q(q), .co(co), .err(err)
    );

    bcd_counter #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clr(clr4), .ld(ld4), .din(din4), .en(en4),
        .up(up4), .lim(lim4), .q(q4), .co(co4), .err(err4)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic idle();
        clr = 0; ld = 0; en = 0;
    endtask

    task automatic load2(input logic [7:0] v);
        clr = 0; ld = 1; en = 0; din = v;
        tick();
        ld = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); up = 1; din = 8'h00; lim = 8'h59;
        clr4 = 0; ld4 = 0; en4 = 0; up4 = 1; din4 = 16'h0; lim4 = 16'h9999;
        #2;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL rst_q actual=%h required=00", q); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err actual=%b required=0", err); end
        tick(); rst_n = 1; tick();
        // Bring q to 37 mid-count, then leave a pending err pulse.
        load2(8'h35);
        en = 1; tick(); tick(); en = 0;
        total++; if (q !== 8'h37) begin bad++; $display("FAIL pre_rst_q actual=%h required=37", q); end
        ld = 1; din = 8'h7A; tick(); ld = 0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL pre_rst_err actual=%b required=1", err); end
        en = 1;
        #2 rst_n = 0;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL async_rst_q actual=%h required=00", q); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL async_rst_err actual=%b required=0", err); end
        #1 rst_n = 1; en = 0;
        tick();
    endtask

    task automatic test_up_wrap();
        int v;
        clr = 1; tick(); idle();
        lim = 8'h59; up = 1; en = 1; v = 0;
        for (int i = 0; i < 61; i++) begin
            total++; if (q !== to_bcd2(v)) begin bad++; $display("FAIL up_q step=%0d actual=%h required=%h", i, q, to_bcd2(v)); end
            total++; if (co !== (v == 59)) begin bad++; $display("FAIL up_co step=%0d actual=%b required=%b", i, co, (v == 59)); end
            tick();
            v = (v + 1) % 60;
        end
        en = 0;
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_q [4] = '{8'h01, 8'h00, 8'h59, 8'h58};
        logic       exp_c [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        lim = 8'h59; up = 0;
        load2(8'h01);
        en = 1;
        for (int i = 0; i < 4; i++) begin
            total++; if (q !== exp_q[i]) begin bad++; $display("FAIL down_q step=%0d actual=%h required=%h", i, q, exp_q[i]); end
            total++; if (co !== exp_c[i]) begin bad++; $display("FAIL down_co step=%0d actual=%b required=%b", i, co, exp_c[i]); end
            tick();
        end
        en = 0;
        load2(8'h50);
        en = 1; tick(); en = 0;
        total++; if (q !== 8'h49) begin bad++; $display("FAIL down_borrow actual=%h required=49", q); end
    endtask

    task automatic test_load();
        lim = 8'h59;
        load2(8'h42);
        total++; if (q !== 8'h42) begin bad++; $display("FAIL ld_ok_q actual=%h required=42", q); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ld_ok_err actual=%b required=0", err); end
        load2(8'h4A);
        total++; if (q !== 8'h42) begin bad++; $display("FAIL ld_bad_digit_q actual=%h required=42", q); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ld_bad_digit_err actual=%b required=1", err); end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ld_err_pulse actual=%b required=0", err); end
        load2(8'h75);
        total++; if (q !== 8'h42) begin bad++; $display("FAIL ld_over_lim_q actual=%h required=42", q); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ld_over_lim_err actual=%b required=1", err); end
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ld_over_lim_pulse actual=%b required=0", err); end
        load2(8'h59);
        total++; if (q !== 8'h59) begin bad++; $display("FAIL ld_eq_lim_q actual=%h required=59", q); end
    endtask

    task automatic test_priority();
        lim = 8'h59; up = 1;
        load2(8'h33);
        clr = 1; ld = 1; en = 1; din = 8'h20; #1;
        total++; if (co !== 1'b0) begin bad++; $display("FAIL prio_clr_co actual=%b required=0", co); end
        tick();
        total++; if (q !== 8'h00) begin bad++; $display("FAIL prio_clr_q actual=%h required=00", q); end
        // Down at 0 would borrow if ld did not mask it.
        clr = 0; ld = 1; en = 1; up = 0; din = 8'h20; #1;
        total++; if (co !== 1'b0) begin bad++; $display("FAIL prio_ld_co actual=%b required=0", co); end
        tick(); idle();
        total++; if (q !== 8'h20) begin bad++; $display("FAIL prio_ld_q actual=%h required=20", q); end
    endtask

    task automatic test_lim_change();
        lim = 8'h59;
        load2(8'h45);
        lim = 8'h30; up = 1; en = 1; #1;
        total++; if (co !== 1'b1) begin bad++; $display("FAIL limchg_up_co actual=%b required=1", co); end
        tick(); en = 0;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL limchg_up_q actual=%h required=00", q); end
        lim = 8'h59;
        load2(8'h45);
        lim = 8'h30; up = 0; en = 1; #1;
        total++; if (co !== 1'b0) begin bad++; $display("FAIL limchg_dn_co actual=%b required=0", co); end
        tick(); en = 0;
        total++; if (q !== 8'h30) begin bad++; $display("FAIL limchg_dn_q actual=%h required=30", q); end
        // Limit 0: pinned at zero, carry on every enabled step in both directions.
        clr = 1; tick(); clr = 0;
        lim = 8'h00; en = 1;
        for (int i = 0; i < 4; i++) begin
            up = i[0]; #1;
            total++; if (co !== 1'b1) begin bad++; $display("FAIL lim0_co step=%0d actual=%b required=1", i, co); end
            tick();
            total++; if (q !== 8'h00) begin bad++; $display("FAIL lim0_q step=%0d actual=%h required=00", i, q); end
        end
        en = 0;
    endtask

    task automatic test_wide();
        lim4 = 16'h9999; up4 = 1;
        ld4 = 1; din4 = 16'h0999; tick(); ld4 = 0;
        total++; if (q4 !== 16'h0999) begin bad++; $display("FAIL wide_ld actual=%h required=0999", q4); end
        en4 = 1; tick();
        total++; if (q4 !== 16'h1000) begin bad++; $display("FAIL wide_up actual=%h required=1000", q4); end
        up4 = 0; tick(); en4 = 0;
        total++; if (q4 !== 16'h0999) begin bad++; $display("FAIL wide_down actual=%h required=0999", q4); end
        ld4 = 1; din4 = 16'h9999; tick(); ld4 = 0;
        up4 = 1; en4 = 1; #1;
        total++; if (co4 !== 1'b1) begin bad++; $display("FAIL wide_co actual=%b required=1", co4); end
        tick(); en4 = 0;
        total++; if (q4 !== 16'h0000) begin bad++; $display("FAIL wide_wrap actual=%h required=0000", q4); end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_priority();
        test_lim_change();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
